// File: rtl/ai_compare_sequencer.sv
// Template-compare sequencer: walks enabled templates, issues one comparison each,
// tracks the best unsigned score and publishes it with a done pulse.
module ai_compare_sequencer #(
    parameter int unsigned N_TMPL  = 8,
    parameter int unsigned W       = 32,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic [7:0]   tmpl_mask,
    input  logic [W-1:0] sum_out,
    input  logic         sum_out_rdy,
    output logic         init,
    output logic         calc_start,
    output logic [2:0]   tmpl_sel,
    output logic         busy,
    output logic         done,
    output logic [3:0]   max,
    output logic [W-1:0] max_score,
    output logic         tmr
);

    localparam int unsigned TW        = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [2:0]  LastIdx   = 3'(N_TMPL - 1);
    localparam logic [TW-1:0] TimerLast = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {StIdle, StInit, StScan, StIssue, StWait, StDone} state_e;

    state_e         state_q, state_d;
    logic [2:0]     idx_q, idx_d;
    logic [7:0]     mask_q, mask_d;
    logic [W-1:0]   best_score_q, best_score_d;
    logic [2:0]     best_idx_q, best_idx_d;
    logic           found_q, found_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic [3:0]     max_q, max_d;
    logic [W-1:0]   max_score_q, max_score_d;
    logic           tmr_q, tmr_d;
    logic [TW-1:0]  timer_inc;

    assign timer_inc = timer_q + TW'(1);

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        mask_d       = mask_q;
        best_score_d = best_score_q;
        best_idx_d   = best_idx_q;
        found_d      = found_q;
        timer_d      = timer_q;
        max_d        = max_q;
        max_score_d  = max_score_q;
        tmr_d        = tmr_q;

        if (abort) begin
            // Abort beats everything, including a start while idle.
            if (state_q != StIdle) begin
                state_d     = StIdle;
                max_d       = 4'b1000;
                max_score_d = '0;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) state_d = StInit;
                end
                StInit: begin
                    idx_d        = '0;
                    best_score_d = '0;
                    best_idx_d   = '0;
                    found_d      = 1'b0;
                    mask_d       = tmpl_mask;
                    tmr_d        = 1'b0;
                    state_d      = StScan;
                end
                StScan: begin
                    if (mask_q[idx_q]) begin
                        state_d = StIssue;
                    end else if (idx_q == LastIdx) begin
                        state_d = StDone;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
                StIssue: begin
                    timer_d = '0;
                    state_d = StWait;
                end
                StWait: begin
                    // A result arriving on the timeout cycle still wins.
                    if (sum_out_rdy) begin
                        if (!found_q || (sum_out > best_score_q)) begin
                            best_score_d = sum_out;
                            best_idx_d   = idx_q;
                            found_d      = 1'b1;
                        end
                        if (idx_q == LastIdx) begin
                            state_d = StDone;
                        end else begin
                            idx_d   = idx_q + 3'd1;
                            state_d = StScan;
                        end
                    end else if (timer_inc == TimerLast) begin
                        tmr_d   = 1'b1;
                        state_d = StDone;
                    end else begin
                        timer_d = timer_inc;
                    end
                end
                StDone: begin
                    max_d       = {!found_q, best_idx_q};
                    max_score_d = found_q ? best_score_q : '0;
                    state_d     = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            mask_q       <= '0;
            best_score_q <= '0;
            best_idx_q   <= '0;
            found_q      <= 1'b0;
            timer_q      <= '0;
            max_q        <= 4'b1000;
            max_score_q  <= '0;
            tmr_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            mask_q       <= mask_d;
            best_score_q <= best_score_d;
            best_idx_q   <= best_idx_d;
            found_q      <= found_d;
            timer_q      <= timer_d;
            max_q        <= max_d;
            max_score_q  <= max_score_d;
            tmr_q        <= tmr_d;
        end
    end

    assign init       = (state_q == StInit);
    assign calc_start = (state_q == StIssue);
    assign busy       = (state_q != StIdle);
    assign done       = (state_q == StDone);
    assign tmpl_sel   = idx_q;
    assign max        = max_q;
    assign max_score  = max_score_q;
    assign tmr        = tmr_q;

endmodule

// File: tb/tb_ai_compare_sequencer.sv
// Directed bench for ai_compare_sequencer: cycle-accurate job walks with hand-derived results.
module tb_ai_compare_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  tmpl_mask = 8'h00;
    logic [31:0] sum_out = '0;
    logic        sum_out_rdy = 1'b0;
    logic        init, calc_start, busy, done, tmr;
    logic [2:0]  tmpl_sel;
    logic [3:0]  max_v;
    logic [31:0] max_score;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] scores [8];
    int          cyc, n_calc, done_cyc, issue_cyc, end_cyc;
    logic [7:0]  sel_seen;
    logic        order_ok, max_moved, init_c1, tmr_c2;

    ai_compare_sequencer #(.N_TMPL(8), .W(32), .TIMEOUT(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .tmpl_mask   (tmpl_mask),
        .sum_out     (sum_out),
        .sum_out_rdy (sum_out_rdy),
        .init        (init),
        .calc_start  (calc_start),
        .tmpl_sel    (tmpl_sel),
        .busy        (busy),
        .done        (done),
        .max         (max_v),
        .max_score   (max_score),
        .tmr         (tmr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".init"}, 64'(init), 64'd0);
        chk({tag, ".calc_start"}, 64'(calc_start), 64'd0);
        chk({tag, ".tmpl_sel"}, 64'(tmpl_sel), 64'd0);
        chk({tag, ".busy"}, 64'(busy), 64'd0);
        chk({tag, ".done"}, 64'(done), 64'd0);
        chk({tag, ".max"}, 64'(max_v), 64'h8);
        chk({tag, ".max_score"}, 64'(max_score), 64'd0);
        chk({tag, ".tmr"}, 64'(tmr), 64'd0);
    endtask

    // Runs one job; cycle 1 is the cycle after the edge that samples start.
    task automatic run_job(input logic [7:0] mask, input logic [7:0] noresp,
                           input int abort_sel, input int rst_sel, input bit busy_start);
        logic        pend;
        logic        stop;
        int          psel;
        int          last_sel;
        logic [3:0]  max0;
        logic [31:0] ms0;
        n_calc = 0; sel_seen = '0; order_ok = 1'b1; max_moved = 1'b0;
        done_cyc = -1; issue_cyc = -1; end_cyc = -1;
        pend = 1'b0; stop = 1'b0; psel = 0; last_sel = -1;
        max0 = max_v; ms0 = max_score;
        tmpl_mask = mask;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        init_c1 = init;
        tmr_c2 = 1'bx;
        while (!stop && cyc < 300) begin
            tick();
            cyc++;
            sum_out_rdy = 1'b0;
            abort = 1'b0;
            start = (busy_start && cyc == 5);
            if (cyc == 2) tmr_c2 = tmr;
            if (pend) begin
                if (psel == abort_sel) begin
                    abort = 1'b1;
                end else if (psel == rst_sel) begin
                    #3 rst = 1'b1;
                    #1 chk_reset_outputs("async_rst");
                    tick();
                    tick();
                    rst = 1'b0;
                    stop = 1'b1;
                end else if (!noresp[psel[2:0]]) begin
                    sum_out_rdy = 1'b1;
                    sum_out = scores[psel];
                end
            end
            pend = 1'b0;
            if (!stop) begin
                if (calc_start) begin
                    psel = int'(tmpl_sel);
                    if (psel <= last_sel) order_ok = 1'b0;
                    last_sel = psel;
                    pend = 1'b1;
                    issue_cyc = cyc;
                    n_calc++;
                    sel_seen[tmpl_sel] = 1'b1;
                end
                if (done) done_cyc = cyc;
                if (!busy) begin
                    end_cyc = cyc;
                    stop = 1'b1;
                end else if (max_v !== max0 || max_score !== ms0) begin
                    max_moved = 1'b1;
                end
            end
        end
        sum_out_rdy = 1'b0;
        abort = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) scores[i] = 32'd100;
        tick();
        tick();
        chk_reset_outputs("reset");
        rst = 1'b0;
        tick();
        chk_reset_outputs("after_reset");

        // All enabled, tie at 50 resolves to template 1.
        scores[0] = 10; scores[1] = 50; scores[2] = 30; scores[3] = 50;
        scores[4] = 5;  scores[5] = 7;  scores[6] = 9;  scores[7] = 1;
        run_job(8'hFF, 8'h00, -1, -1, 1'b0);
        chk("full.init_c1", 64'(init_c1), 64'd1);
        chk("full.n_calc", 64'(n_calc), 64'd8);
        chk("full.sel_seen", 64'(sel_seen), 64'hFF);
        chk("full.order", 64'(order_ok), 64'd1);
        chk("full.done_cyc", 64'(done_cyc), 64'd26);
        chk("full.end_cyc", 64'(end_cyc), 64'd27);
        chk("full.max", 64'(max_v), 64'h1);
        chk("full.max_score", 64'(max_score), 64'd50);
        chk("full.tmr", 64'(tmr), 64'd0);
        chk("full.stable", 64'(max_moved), 64'd0);

        // Nothing enabled.
        run_job(8'h00, 8'h00, -1, -1, 1'b0);
        chk("empty.init_c1", 64'(init_c1), 64'd1);
        chk("empty.done_cyc", 64'(done_cyc), 64'd10);
        chk("empty.n_calc", 64'(n_calc), 64'd0);
        chk("empty.max", 64'(max_v), 64'h8);
        chk("empty.max_score", 64'(max_score), 64'd0);

        // Template 1 never answers.
        scores[0] = 9;
        run_job(8'h03, 8'h02, -1, -1, 1'b0);
        chk("tmo.n_calc", 64'(n_calc), 64'd2);
        chk("tmo.issue_cyc", 64'(issue_cyc), 64'd6);
        chk("tmo.done_cyc", 64'(done_cyc), 64'd22);
        chk("tmo.done_after_issue", 64'(done_cyc - issue_cyc), 64'd16);
        chk("tmo.tmr", 64'(tmr), 64'd1);
        chk("tmo.max", 64'(max_v), 64'h0);
        chk("tmo.max_score", 64'(max_score), 64'd9);

        // Abort in WAIT of template 3, with a start pulsed mid-job.
        for (int i = 0; i < 8; i++) scores[i] = 32'd20 + 32'(i);
        run_job(8'hFF, 8'h00, 3, -1, 1'b1);
        chk("abort.tmr_cleared", 64'(tmr_c2), 64'd0);
        chk("abort.end_cyc", 64'(end_cyc), 64'd14);
        chk("abort.no_done", 64'(done_cyc), 64'hFFFF_FFFF_FFFF_FFFF);
        chk("abort.stable", 64'(max_moved), 64'd0);
        chk("abort.max", 64'(max_v), 64'h8);
        chk("abort.max_score", 64'(max_score), 64'd0);
        sum_out = 32'h1234;
        sum_out_rdy = 1'b1;
        tick();
        tick();
        tick();
        sum_out_rdy = 1'b0;
        tick();
        chk("idle.busy", 64'(busy), 64'd0);
        chk("idle.max", 64'(max_v), 64'h8);
        chk("idle.max_score", 64'(max_score), 64'd0);

        // Sparse mask with an all-ones score.
        for (int i = 0; i < 8; i++) scores[i] = 32'd100;
        scores[2] = 32'hFFFF_FFFF;
        scores[5] = 32'd3;
        run_job(8'h24, 8'h00, -1, -1, 1'b0);
        chk("sparse.n_calc", 64'(n_calc), 64'd2);
        chk("sparse.sel_seen", 64'(sel_seen), 64'h24);
        chk("sparse.done_cyc", 64'(done_cyc), 64'd14);
        chk("sparse.max", 64'(max_v), 64'h2);
        chk("sparse.max_score", 64'(max_score), 64'hFFFF_FFFF);

        // Async reset in WAIT of template 2, then a clean job.
        run_job(8'hFF, 8'h00, -1, 2, 1'b0);
        tick();
        chk_reset_outputs("post_rst");
        for (int i = 0; i < 7; i++) scores[i] = 32'd3;
        scores[7] = 32'd8;
        run_job(8'hFF, 8'h00, -1, -1, 1'b0);
        chk("recover.done_cyc", 64'(done_cyc), 64'd26);
        chk("recover.n_calc", 64'(n_calc), 64'd8);
        chk("recover.max", 64'(max_v), 64'h7);
        chk("recover.max_score", 64'(max_score), 64'd8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ai_compare_sequencer.md
# ai_compare_sequencer

Sequencer for the comparer datapath. On a start command it walks the stored speech templates in order and issues one comparison per enabled template to the score accumulator. It collects each `sum_out` result, tracks the best (largest) score and its index, and publishes `max`/`max_score` with a `done` pulse. Its `init` pulse clears the result store of the Avalon reader, and its `tmr` flag feeds that reader's status word.

## Interface
- `N_TMPL`, default 8: number of templates; `tmpl_sel` width is 3, so `N_TMPL` is at most 8.
- `W`, default 32: score width.
- `TIMEOUT`, default 4096: maximum cycles spent waiting for `sum_out_rdy` per template.

Ports:
- `clk` in 1: the single clock. All logic is on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: start a job. Sampled only in IDLE.
- `abort` in 1: cancel the current job. Takes priority over every other input.
- `tmpl_mask` in 8: enabled templates. Bit i enables template i. Sampled in INIT.
- `sum_out` in W: score from the accumulator, unsigned.
- `sum_out_rdy` in 1: `sum_out` valid. Ignored outside WAIT.
- `init` out 1: one-cycle pulse at job start.
- `calc_start` out 1: one-cycle pulse that launches the comparison for `tmpl_sel`.
- `tmpl_sel` out 3: current template index.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at job completion.
- `max` out 4: `{none, idx[2:0]}`. `none`=1 means no result is available.
- `max_score` out W: best score from the last completed job.
- `tmr` out 1: sticky timeout flag.

## Operation
- States are IDLE, INIT, SCAN, ISSUE, WAIT, DONE.
- IDLE
  - `start`=1 → INIT.
  - `start` while busy is ignored (no queueing).
- INIT (1 cycle)
  - `init`=1.
  - idx←0; best_score←0; best_idx←0; found←0; mask_q←`tmpl_mask`; `tmr`←0.
  - → SCAN.
- SCAN (1 cycle)
  - If mask_q[idx]=1 → ISSUE.
  - Else if idx=N_TMPL-1 → DONE.
  - Else idx←idx+1, stay in SCAN.
- ISSUE (1 cycle)
  - `calc_start`=1; wait timer←0.
  - → WAIT.
- WAIT
  - On `sum_out_rdy`=1:
    - If !found or `sum_out` > best_score (unsigned, strict): best_score←`sum_out`, best_idx←idx, found←1.
    - Then if idx=N_TMPL-1 → DONE, else idx←idx+1 → SCAN.
  - Otherwise the timer increments. When the timer reaches TIMEOUT-1 without `sum_out_rdy`: `tmr`←1 → DONE. Results gathered so far are kept.
  - If `sum_out_rdy` arrives in the same cycle as the timeout, the result is accepted and no timeout is flagged.
- DONE (1 cycle)
  - `done`=1.
  - `max`←{!found, best_idx}; `max_score`←found ? best_score : 0.
  - → IDLE.
- Ties: the lower index wins, because the compare is strict.
- `max`/`max_score` change only in DONE and stay stable during a job.
- `tmpl_sel` is always equal to idx.
- abort (any non-IDLE state)
  - → IDLE on the next edge; no `done` pulse.
  - `max`←4'b1000, `max_score`←0. `tmr` is unchanged.
  - A `start` in the same cycle as `abort` is ignored.
- `rst` mid-job: immediate return to IDLE with reset values on all outputs.

## Timing
- Reset values:
  - State IDLE.
  - `init`=0, `calc_start`=0, `tmpl_sel`=0, `busy`=0, `done`=0.
  - `max`=4'b1000, `max_score`=0, `tmr`=0.
- All outputs are registered or decoded from the registered state; there are no combinational paths from inputs to outputs.
- Relative to `start` sampled at edge 0:
  - `init` is high in cycle 1.
  - The first SCAN is in cycle 2.
- Cost per template:
  - Enabled: SCAN, ISSUE, then WAIT for at least 1 cycle. `sum_out_rdy` is accepted no earlier than the cycle after `calc_start`.
  - Disabled: 1 SCAN cycle.
- All 8 templates enabled with `rdy` in the first WAIT cycle:
  - `done` in cycle 26.
  - `max` is valid from cycle 27.
- `tmpl_mask`=0: `done` in cycle 10 with `max`=4'b1000.
- Timeout: `tmr` is set and DONE is entered TIMEOUT cycles after ISSUE.

## Test plan
- Mask 0xFF; scores 10,50,30,50,5,7,9,1, each with `rdy` one cycle after `calc_start` → exactly 8 `calc_start` pulses with `tmpl_sel` 0..7; `done` in cycle 26; `max`=4'b0001; `max_score`=50 (tie resolved to the lower index).
- Mask 0x24; scores 0xFFFF_FFFF (template 2) and 3 (template 5) → only `tmpl_sel` 2 and 5 are issued; `max`=4'b0010; `max_score`=0xFFFF_FFFF (unsigned compare).
- Mask 0x00 → `init` in cycle 1, `done` in cycle 10, no `calc_start`, `max`=4'b1000, `max_score`=0.
- TIMEOUT=16; mask 0x03; template 0 scores 9; template 1 never asserts `rdy` → `tmr`=1; `done` 16 cycles after the second ISSUE; `max`=4'b0000; `max_score`=9. The next `start` clears `tmr` in INIT.
- `abort` during WAIT of template 3 → IDLE on the next edge; no `done`; `max`=4'b1000. A `start` pulsed while busy earlier in the job has no effect, and a stray `sum_out_rdy` while IDLE leaves the outputs unchanged.
- Assert `rst` asynchronously in the middle of WAIT → all outputs take their reset values before the next `clk` edge. A new job after reset completes normally.
